register_file_param: RTL and testbench

- Parametrised MIPS register file with configurable word width, register count and stack-pointer reset value.
- Provides two read ports through a parametrised N:1 read multiplexer and one synchronous write port.
- Read results are captured in output registers, the A/B operand latches of the multicycle datapath, under a read-enable.
- Includes write-to-read bypass and a hardwired zero register.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/reg_read_mux_param.sv | 42 ++++
 rtl/register_file_param.sv | 122 ++++++++++++
 tb/tb_register_file_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS register-file constants: architectural register
//                indices, default datapath widths and an elaboration-time
//                ceil(log2) helper used to validate address widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int ZERO_REG = 0;
    localparam int SP_REG   = 29;
    localparam int GP_REG   = 28;
    localparam int RA_REG   = 31;

    localparam int DEF_WORD_LENGTH = 32;
    localparam int DEF_ADDR_WIDTH  = 5;

    // Number of address bits needed to index 'value' distinct entries.
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/reg_read_mux_param.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_mux_param
//  Description : Combinational N:1 register read multiplexer. Selects one
//                WORD_LENGTH slice of a packed register bus. Select 0 and
//                selects at or above NBREGS both return zero.
//  Ports       : regs_bus (in)  packed NBREGS*WORD_LENGTH register contents
//                sel      (in)  ADDR_WIDTH register index
//                data     (out) selected word
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_read_mux_param
    import mips_pkg::*;
#(
    parameter int WORD_LENGTH = DEF_WORD_LENGTH,
    parameter int NBREGS      = 32,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic [NBREGS*WORD_LENGTH-1:0] regs_bus,
    input  logic [ADDR_WIDTH-1:0]         sel,
    output logic [WORD_LENGTH-1:0]        data
);

    logic w_sel_nonzero;

    assign w_sel_nonzero = (sel != ADDR_WIDTH'(ZERO_REG));

    // Slot 0 is masked here so the mux returns zero for register 0 regardless
    // of what the caller places in that slot. No match (out of range) leaves
    // the zero default in place.
    always_comb begin
        data = '0;
        for (int i = 0; i < NBREGS; i++) begin
            if (sel == ADDR_WIDTH'(i)) begin
                data = regs_bus[i*WORD_LENGTH +: WORD_LENGTH]
                     & {WORD_LENGTH{w_sel_nonzero}};
            end
        end
    end

endmodule : reg_read_mux_param
`default_nettype wire

// File: rtl/register_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_param
//  Description : Parametrised MIPS register file, two registered read ports
//                (operand A/B latches) and one synchronous write port, with
//                write-to-read bypass and a hardwired zero register.
//  Ports       : clk             (in)  system clock, rising edge
//                reset           (in)  asynchronous active-low reset
//                Reg_Write       (in)  write enable
//                Write_Register  (in)  destination index
//                Write_Data      (in)  write data
//                Read_Enable     (in)  loads both read-output registers
//                Read_Register_1 (in)  read port 1 index
//                Read_Register_2 (in)  read port 2 index
//                Read_Data_1     (out) registered operand A
//                Read_Data_2     (out) registered operand B
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_param
    import mips_pkg::*;
#(
    parameter int                     WORD_LENGTH = DEF_WORD_LENGTH,
    parameter int                     NBREGS      = 32,
    parameter int                     ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                     SP_INDEX    = SP_REG,
    parameter logic [WORD_LENGTH-1:0] SP_INIT     = 32'h7FFF_EFFC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Reg_Write,
    input  logic [ADDR_WIDTH-1:0]  Write_Register,
    input  logic [WORD_LENGTH-1:0] Write_Data,
    input  logic                   Read_Enable,
    input  logic [ADDR_WIDTH-1:0]  Read_Register_1,
    input  logic [ADDR_WIDTH-1:0]  Read_Register_2,
    output logic [WORD_LENGTH-1:0] Read_Data_1,
    output logic [WORD_LENGTH-1:0] Read_Data_2
);

    generate
        if (NBREGS < 2 || NBREGS > 32 || ADDR_WIDTH < clog2(NBREGS)) begin : g_param_check
            $error("register_file_param: illegal NBREGS/ADDR_WIDTH combination");
        end
    endgenerate

    logic [NBREGS*WORD_LENGTH-1:0] w_regs_bus;
    logic [NBREGS-1:0]             w_we;
    logic                          w_wr_hit;
    logic                          w_bypass_1;
    logic                          w_bypass_2;
    logic [WORD_LENGTH-1:0]        w_mux_1;
    logic [WORD_LENGTH-1:0]        w_mux_2;
    logic [WORD_LENGTH-1:0]        r_read_data_1;
    logic [WORD_LENGTH-1:0]        r_read_data_2;

    // Register 0 has no storage; its bus slot is tied to zero.
    assign w_regs_bus[WORD_LENGTH-1:0] = '0;
    assign w_we[0]                     = 1'b0;

    generate
        for (genvar i = 1; i < NBREGS; i++) begin : g_regs
            localparam logic [WORD_LENGTH-1:0] c_rst_val =
                (i == SP_INDEX) ? SP_INIT : '0;

            logic [WORD_LENGTH-1:0] r_reg;

            // Indices >= NBREGS never decode, so out-of-range writes drop.
            assign w_we[i] = Reg_Write && (Write_Register == ADDR_WIDTH'(i));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_reg <= c_rst_val;
                end else if (w_we[i]) begin
                    r_reg <= Write_Data;
                end
            end

            assign w_regs_bus[i*WORD_LENGTH +: WORD_LENGTH] = r_reg;
        end
    endgenerate

    // A write only lands when it decodes to a real storage register, which
    // is exactly the condition under which forwarding is allowed.
    assign w_wr_hit   = |w_we;
    assign w_bypass_1 = w_wr_hit && (Read_Register_1 == Write_Register);
    assign w_bypass_2 = w_wr_hit && (Read_Register_2 == Write_Register);

    reg_read_mux_param #(
        .WORD_LENGTH (WORD_LENGTH),
        .NBREGS      (NBREGS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_mux_1 (
        .regs_bus (w_regs_bus),
        .sel      (Read_Register_1),
        .data     (w_mux_1)
    );

    reg_read_mux_param #(
        .WORD_LENGTH (WORD_LENGTH),
        .NBREGS      (NBREGS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_mux_2 (
        .regs_bus (w_regs_bus),
        .sel      (Read_Register_2),
        .data     (w_mux_2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_data_1 <= '0;
            r_read_data_2 <= '0;
        end else if (Read_Enable) begin
            r_read_data_1 <= w_bypass_1 ? Write_Data : w_mux_1;
            r_read_data_2 <= w_bypass_2 ? Write_Data : w_mux_2;
        end
    end

    assign Read_Data_1 = r_read_data_1;
    assign Read_Data_2 = r_read_data_2;

endmodule : register_file_param
`default_nettype wire

// File: tb/tb_register_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_param
//  Description : Scoreboard bench for register_file_param. Two instances: the
//                default 32x32 configuration and a 16x16 configuration.
//                Stimulus pushes expected operand pairs; monitors pop them on
//                each read-enabled edge and compare the held outputs on every
//                falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_param;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        string       name;
    } exp_t;

    logic clk;
    int   errors;
    int   checks;

    exp_t q32[$];
    exp_t q16[$];

    // 32-bit instance signals
    logic        rst32, we32, re32;
    logic [4:0]  wa32, a1_32, a2_32;
    logic [31:0] wd32, rd1_32, rd2_32;

    // 16-bit instance signals
    logic        rst16, we16, re16;
    logic [4:0]  wa16, a1_16, a2_16;
    logic [15:0] wd16, rd1_16, rd2_16;

    register_file_param u_dut32 (
        .clk             (clk),
        .reset           (rst32),
        .Reg_Write       (we32),
        .Write_Register  (wa32),
        .Write_Data      (wd32),
        .Read_Enable     (re32),
        .Read_Register_1 (a1_32),
        .Read_Register_2 (a2_32),
        .Read_Data_1     (rd1_32),
        .Read_Data_2     (rd2_32)
    );

    register_file_param #(
        .WORD_LENGTH (16),
        .NBREGS      (16),
        .ADDR_WIDTH  (5),
        .SP_INIT     (16'hEFFC)
    ) u_dut16 (
        .clk             (clk),
        .reset           (rst16),
        .Reg_Write       (we16),
        .Write_Register  (wa16),
        .Write_Data      (wd16),
        .Read_Enable     (re16),
        .Read_Register_1 (a1_16),
        .Read_Register_2 (a2_16),
        .Read_Data_1     (rd1_16),
        .Read_Data_2     (rd2_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor for the 32-bit instance.
    initial begin
        exp_t cur;
        cur = '{32'h0, 32'h0, "reset32"};
        forever begin
            @(posedge clk);
            if (rst32 && re32) begin
                if (q32.size() == 0) begin
                    chk("q32 underflow", 32'h1, 32'h0);
                end else begin
                    cur = q32.pop_front();
                end
            end
            @(negedge clk);
            if (!rst32) cur = '{32'h0, 32'h0, "reset32"};
            chk({cur.name, " rd1"}, rd1_32, cur.d1);
            chk({cur.name, " rd2"}, rd2_32, cur.d2);
        end
    end

    // Monitor for the 16-bit instance.
    initial begin
        exp_t cur;
        cur = '{32'h0, 32'h0, "reset16"};
        forever begin
            @(posedge clk);
            if (rst16 && re16) begin
                if (q16.size() == 0) begin
                    chk("q16 underflow", 32'h1, 32'h0);
                end else begin
                    cur = q16.pop_front();
                end
            end
            @(negedge clk);
            if (!rst16) cur = '{32'h0, 32'h0, "reset16"};
            chk({cur.name, " rd1"}, {16'h0, rd1_16}, cur.d1);
            chk({cur.name, " rd2"}, {16'h0, rd2_16}, cur.d2);
        end
    end

    // Drive one cycle on the 32-bit instance; called just after a falling edge.
    task automatic s32(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2, input string nm);
        we32 = we; wa32 = wa; wd32 = wd;
        re32 = re; a1_32 = a1; a2_32 = a2;
        if (re) q32.push_back('{e1, e2, nm});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic s16(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                       input logic re, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] e1, input logic [31:0] e2, input string nm);
        we16 = we; wa16 = wa; wd16 = wd;
        re16 = re; a1_16 = a1; a2_16 = a2;
        if (re) q16.push_back('{e1, e2, nm});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst32 = 1'b0; we32 = 1'b0; re32 = 1'b0; wa32 = '0; wd32 = '0; a1_32 = '0; a2_32 = '0;
        rst16 = 1'b0; we16 = 1'b0; re16 = 1'b0; wa16 = '0; wd16 = '0; a1_16 = '0; a2_16 = '0;

        #1;
        chk("reset rd1_32", rd1_32, 32'h0);
        chk("reset rd2_32", rd2_32, 32'h0);
        repeat (2) @(negedge clk);
        rst32 = 1'b1;
        rst16 = 1'b1;

        // ---------------- 32-bit instance ----------------
        s32(1'b0, 5'd0, 32'h0, 1'b1, 5'(SP_REG), 5'd5, 32'h7FFF_EFFC, 32'h0, "sp_init");
        s32(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "");
        s32(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rd8_both");
        s32(1'b1, 5'(ZERO_REG), 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "");
        s32(1'b0, 5'd0, 32'h0, 1'b1, 5'(ZERO_REG), 5'd8, 32'h0, 32'hDEAD_BEEF, "zero_reg");
        s32(1'b1, 5'd13, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "");
        s32(1'b1, 5'd12, 32'h1234_5678, 1'b1, 5'd12, 5'd13, 32'h1234_5678, 32'hA5A5_A5A5, "bypass1");
        s32(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd12, 32'hDEAD_BEEF, 32'h1234_5678, "rd8_12");
        // Outputs must hold while reg 8 is rewritten with reads disabled.
        s32(1'b1, 5'd8, 32'h0000_0001, 1'b0, 5'd8, 5'd8, 32'h0, 32'h0, "");
        s32(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd8, 32'h0000_0001, 32'h0000_0001, "rd8_new");
        s32(1'b1, 5'(RA_REG), 32'hCAFE_F00D, 1'b1, 5'(RA_REG), 5'(RA_REG),
            32'hCAFE_F00D, 32'hCAFE_F00D, "bypass_both");
        s32(1'b1, 5'(GP_REG), 32'h1000_8000, 1'b1, 5'(RA_REG), 5'(SP_REG),
            32'hCAFE_F00D, 32'h7FFF_EFFC, "rd31_29");
        s32(1'b1, 5'(ZERO_REG), 32'h0000_0055, 1'b1, 5'(ZERO_REG), 5'(GP_REG),
            32'h0, 32'h1000_8000, "no_bypass_r0");
        s32(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "");
        s32(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "");

        // ---------------- 16-bit instance ----------------
        s16(1'b1, 5'd20, 16'hBEEF, 1'b1, 5'd20, 5'd1, 32'h0, 32'h0, "oor_bypass");
        s16(1'b0, 5'd0, 16'h0, 1'b1, 5'd20, 5'd29, 32'h0, 32'h0, "oor_read");
        s16(1'b1, 5'd15, 16'h1234, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "");
        s16(1'b1, 5'd3, 16'h00FF, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "");
        s16(1'b0, 5'd0, 16'h0, 1'b1, 5'd3, 5'd15, 32'h0000_00FF, 32'h0000_1234, "rd3_15");

        // Reset mid-cycle while a write to reg 4 is pending.
        we16 = 1'b1; wa16 = 5'd4; wd16 = 16'hABCD; re16 = 1'b0;
        #2;
        rst16 = 1'b0;
        #1;
        chk("async rd1_16", {16'h0, rd1_16}, 32'h0);
        chk("async rd2_16", {16'h0, rd2_16}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst16 = 1'b1;
        we16  = 1'b0;
        s16(1'b0, 5'd0, 16'h0, 1'b1, 5'd3, 5'd4, 32'h0, 32'h0, "post_reset");
        s16(1'b0, 5'd0, 16'h0, 1'b1, 5'd15, 5'd4, 32'h0, 32'h0, "post_reset15");
        s16(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "");
        s16(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, "");

        chk("q32 drained", 32'(q32.size()), 32'h0);
        chk("q16 drained", 32'(q16.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_register_file_param
`default_nettype wire
